// File: rtl/mul_share_if.sv
// mul_share_if: request/response channels between requesters and the shared-multiplier arbiter
//   req_valid/req_ready/req_a/req_b  : per-requester request channel, 32-bit lanes packed by index
//   resp_valid/resp_ready            : response handshake
//   resp_id/resp_product             : owning requester and signed 64-bit product
//   master = requester side, slave = arbiter side
interface mul_share_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [32*NUM_REQ-1:0] req_a;
    logic [32*NUM_REQ-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [63:0]           resp_product;
    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_product
    );
    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_product
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one 32x32 signed sequential multiplier among NUM_REQ requesters
//   clk, rst          : clock, asynchronous active-high reset
//   bus (slave)       : request channels in, tagged 64-bit response out
//   mul_start         : one-cycle start pulse to the multiplier
//   mul_multiplicand,
//   mul_multiplier    : registered operands, held stable for the whole operation
//   mul_product,
//   mul_done          : multiplier result and level done flag
//   busy              : high whenever not IDLE
//   Optional: define MUL_SHARE_ZERO_BYPASS_EN to answer zero-operand requests directly
module mul_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic          clk,
    input  logic          rst,
    mul_share_if.slave    bus,
    output logic          mul_start,
    output logic [31:0]   mul_multiplicand,
    output logic [31:0]   mul_multiplier,
    input  logic [63:0]   mul_product,
    input  logic          mul_done,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t          state, next_state;
    logic [ID_W-1:0] rr_last;
    logic [ID_W-1:0] grant;
    logic            found;
    logic            accept;
    logic            bypass;
    logic            wait_first;
    logic [31:0]     sel_a, sel_b;
    int              idx;

    // First valid requester after the last grant, wrapping around
    always_comb begin
        grant = '0;
        found = 1'b0;
        sel_a = '0;
        sel_b = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_last) + k) % NUM_REQ;
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
                sel_a = bus.req_a[32*idx +: 32];
                sel_b = bus.req_b[32*idx +: 32];
            end
        end
    end

    assign accept = (state == IDLE) && found;

`ifdef MUL_SHARE_ZERO_BYPASS_EN
    assign bypass = accept && (sel_a == '0 || sel_b == '0);
`else
    assign bypass = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next_state;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? (bypass ? RESP : ISSUE) : IDLE;
            ISSUE:   next_state = WAIT;
            WAIT:    next_state = (!wait_first && mul_done) ? RESP : WAIT;
            default: next_state = bus.resp_ready ? IDLE : RESP;
        endcase
    end

    always_comb begin
        mul_start     = (state == ISSUE);
        busy          = (state != IDLE);
        bus.req_ready = accept ? NUM_REQ'(1) << grant : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last          <= ID_W'(NUM_REQ - 1);
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            bus.resp_id      <= '0;
            bus.resp_product <= '0;
            bus.resp_valid   <= 1'b0;
            wait_first       <= 1'b0;
        end else begin
            // Set for exactly the first WAIT cycle so a stale done is not taken
            wait_first <= (state == ISSUE);
            if (accept) begin
                mul_multiplicand <= sel_a;
                mul_multiplier   <= sel_b;
                bus.resp_id      <= grant;
                rr_last          <= grant;
            end
            if (bypass) begin
                bus.resp_product <= '0;
                bus.resp_valid   <= 1'b1;
            end
            if (state == WAIT && !wait_first && mul_done) begin
                bus.resp_product <= mul_product;
                bus.resp_valid   <= 1'b1;
            end
            if (state == RESP && bus.resp_ready) bus.resp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed self-checking bench with a 35-cycle sequential multiplier model
module tb_mul_share_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mul_start;
    logic [31:0] mul_multiplicand, mul_multiplier;
    logic [63:0] mul_product;
    logic        mul_done;
    logic        busy;
    int          errors = 0;
    int          checks = 0;
    int          mcnt;
    logic [31:0] ma, mb;

    mul_share_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    mul_share_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .mul_start(mul_start), .mul_multiplicand(mul_multiplicand),
        .mul_multiplier(mul_multiplier), .mul_product(mul_product),
        .mul_done(mul_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier: done clears on the start edge and rises 35 cycles later
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done <= 1'b0; mcnt <= 0; mul_product <= '0; ma <= '0; mb <= '0;
        end else if (mul_start) begin
            mul_done <= 1'b0; mcnt <= 35; ma <= mul_multiplicand; mb <= mul_multiplier;
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                mul_done    <= 1'b1;
                mul_product <= {{32{ma[31]}}, ma} * {{32{mb[31]}}, mb};
            end
        end
    end

    task automatic reset_dut();
        rst = 1'b1;
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          output logic [1:0] rid, output logic [63:0] rp,
                          output int starts, output int cyc);
        int w = 0;
        @(negedge clk);
        bus.resp_ready = 1'b1;
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
        bus.req_valid[id] = 1'b1;
        #1;
        while (!bus.req_ready[id] && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        cyc = 1;
        starts = int'(mul_start);
        while (!bus.resp_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
            starts += int'(mul_start);
        end
        checks++;
        if (!bus.resp_valid) begin
            errors++;
            $display("FAIL op_timeout id=%0d: got resp_valid=0 after %0d cycles, expected 1", id, cyc);
        end
        rid = bus.resp_id;
        rp  = bus.resp_product;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_dut();
        checks += 8;
        if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready); end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", bus.resp_valid); end
        if (bus.resp_id !== 2'd0) begin errors++; $display("FAIL rst_resp_id got=%0d exp=0", bus.resp_id); end
        if (bus.resp_product !== 64'd0) begin errors++; $display("FAIL rst_resp_product got=%h exp=0", bus.resp_product); end
        if (mul_start !== 1'b0) begin errors++; $display("FAIL rst_mul_start got=%b exp=0", mul_start); end
        if (mul_multiplicand !== 32'd0) begin errors++; $display("FAIL rst_multiplicand got=%h exp=0", mul_multiplicand); end
        if (mul_multiplier !== 32'd0) begin errors++; $display("FAIL rst_multiplier got=%h exp=0", mul_multiplier); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        logic [1:0] rid; logic [63:0] rp; int st, cyc;
        reset_dut();
        run_op(2, 32'd7, -32'sd3, rid, rp, st, cyc);
        checks += 5;
        if (rid !== 2'd2) begin errors++; $display("FAIL single_id got=%0d exp=2", rid); end
        if (rp !== 64'hFFFFFFFFFFFFFFEB) begin errors++; $display("FAIL single_product got=%h exp=ffffffffffffffeb", rp); end
        if (st !== 1) begin errors++; $display("FAIL single_starts got=%0d exp=1", st); end
        if (cyc < 30) begin errors++; $display("FAIL single_latency got=%0d exp>=30", cyc); end
        if (busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle got busy=%b resp_valid=%b exp 0 0", busy, bus.resp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]  ids [5];
        logic [63:0] prods [5];
        logic [1:0]  exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [63:0] exp_p [5]  = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd10};
        int n = 0, multi = 0, c = 0;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[32*i +: 32] = 32'(i + 1);
            bus.req_b[32*i +: 32] = 32'd10;
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'b1111;
        while (n < 5 && c < 400) begin
            #1;
            if ($countones(bus.req_ready) > 1) multi++;
            if (bus.resp_valid) begin ids[n] = bus.resp_id; prods[n] = bus.resp_product; n++; end
            if (n < 5) @(negedge clk);
            c++;
        end
        bus.req_valid = '0;
        checks++;
        if (n != 5) begin errors++; $display("FAIL rr_count got=%0d exp=5", n); end
        checks++;
        if (multi != 0) begin errors++; $display("FAIL rr_onehot got=%0d multi-hot cycles exp=0", multi); end
        for (int i = 0; i < n; i++) begin
            checks += 2;
            if (ids[i] !== exp_id[i]) begin errors++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", i, ids[i], exp_id[i]); end
            if (prods[i] !== exp_p[i]) begin errors++; $display("FAIL rr_product[%0d] got=%0d exp=%0d", i, prods[i], exp_p[i]); end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int c = 0;
        reset_dut();
        bus.req_a[63:32] = 32'd5; bus.req_b[63:32] = 32'd6;
        bus.req_valid[1] = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant got=%b exp=0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        while (!bus.resp_valid && c < 200) begin @(negedge clk); c++; end
        bus.req_valid[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks += 5;
            if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, bus.resp_valid); end
            if (bus.resp_id !== 2'd1) begin errors++; $display("FAIL bp_id[%0d] got=%0d exp=1", i, bus.resp_id); end
            if (bus.resp_product !== 64'd30) begin errors++; $display("FAIL bp_product[%0d] got=%0d exp=30", i, bus.resp_product); end
            if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL bp_req_ready[%0d] got=%b exp=0000", i, bus.req_ready); end
            if (mul_start !== 1'b0) begin errors++; $display("FAIL bp_mul_start[%0d] got=%b exp=0", i, mul_start); end
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks += 2;
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", bus.resp_valid); end
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_next_grant got=%b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_extremes();
        logic [1:0] rid; logic [63:0] rp; int st, cyc;
        reset_dut();
        run_op(0, 32'h80000000, 32'h80000000, rid, rp, st, cyc);
        checks++;
        if (rp !== 64'h4000000000000000) begin errors++; $display("FAIL ext_minmin got=%h exp=4000000000000000", rp); end
        run_op(3, 32'h80000000, 32'h00000001, rid, rp, st, cyc);
        checks += 2;
        if (rp !== 64'hFFFFFFFF80000000) begin errors++; $display("FAIL ext_min1 got=%h exp=ffffffff80000000", rp); end
        if (rid !== 2'd3) begin errors++; $display("FAIL ext_id got=%0d exp=3", rid); end
    endtask

    task automatic test_reset_in_wait();
        reset_dut();
        bus.req_a[31:0] = 32'd3; bus.req_b[31:0] = 32'd4;
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        checks++;
        if (mul_start !== 1'b1) begin errors++; $display("FAIL rw_start got=%b exp=1", mul_start); end
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy got=%b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks += 5;
        if (busy !== 1'b0) begin errors++; $display("FAIL rw_rst_busy got=%b exp=0", busy); end
        if (mul_start !== 1'b0) begin errors++; $display("FAIL rw_rst_start got=%b exp=0", mul_start); end
        if (mul_multiplicand !== 32'd0 || mul_multiplier !== 32'd0) begin
            errors++; $display("FAIL rw_rst_operands got=%h,%h exp=0,0", mul_multiplicand, mul_multiplier);
        end
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rw_rst_resp_valid got=%b exp=0", bus.resp_valid); end
        if (bus.resp_id !== 2'd0) begin errors++; $display("FAIL rw_rst_resp_id got=%0d exp=0", bus.resp_id); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        bus.req_valid = 4'b1001;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rw_tie got=%b exp=0001", bus.req_ready); end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_zero_operand();
        logic [1:0] rid; logic [63:0] rp; int st, cyc;
        reset_dut();
        run_op(1, 32'd0, 32'd12345, rid, rp, st, cyc);
        checks += 4;
        if (rp !== 64'd0) begin errors++; $display("FAIL zero_product got=%h exp=0", rp); end
        if (rid !== 2'd1) begin errors++; $display("FAIL zero_id got=%0d exp=1", rid); end
`ifdef MUL_SHARE_ZERO_BYPASS_EN
        if (st !== 0) begin errors++; $display("FAIL zero_starts got=%0d exp=0", st); end
        if (cyc !== 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", cyc); end
`else
        if (st !== 1) begin errors++; $display("FAIL zero_starts got=%0d exp=1", st); end
        if (cyc < 30) begin errors++; $display("FAIL zero_latency got=%0d exp>=30", cyc); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_reset_in_wait();
        test_zero_operand();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
